calc_arbiter: RTL and testbench

- Two-requester front end that shares one combinational signed calculator datapath (opcode-selected add, subtract, absolute value).
- Arbitrates round-robin and accepts at most one request per cycle over a valid/ready handshake.
- Registers the result and returns it to the winning requester one cycle later.
- Keeps a sticky overflow flag per requester for software/status polling.

---
 rtl/calc_arbiter.sv | 62 ++++++
 tb/tb_calc_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin two-requester front end sharing one registered signed add/sub/abs datapath with per-requester sticky overflow; ports: clk, reset, en, req{0,1}_{valid,ready,op,a,b}, rsp{0,1}_valid, rsp_r, rsp_ovf, ovf_sticky, ovf_clr
module calc_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_r,
  output logic         rsp_ovf,
  output logic [1:0]   ovf_sticky,
  input  logic [1:0]   ovf_clr
);
  logic         last_grant;
  logic [2:0]   op;
  logic [W-1:0] x, y, sum, dif, mag, r;
  logic         ovf;
  always_comb begin
    req0_ready = en & ~reset & req0_valid & (~req1_valid | last_grant);
    req1_ready = en & ~reset & req1_valid & (~req0_valid | ~last_grant);
    op  = req1_ready ? req1_op : req0_op;
    x   = op[2] ? (req1_ready ? req1_b : req0_b) : (req1_ready ? req1_a : req0_a);
    y   = op[2] ? (req1_ready ? req1_a : req0_a) : (req1_ready ? req1_b : req0_b);
    sum = x + y;
    dif = x - y;
    mag = y[W-1] ? -y : y;
    r   = op[1] ? mag : op[0] ? dif : sum;
    ovf = op[1] ? (y[W-1] & mag[W-1])
        : op[0] ? ((x[W-1] != y[W-1]) && (dif[W-1] != x[W-1]))
        : ((x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_r      <= '0;
      rsp_ovf    <= 1'b0;
      ovf_sticky <= 2'b00;
      last_grant <= 1'b1;
    end else begin
      rsp0_valid <= req0_ready;
      rsp1_valid <= req1_ready;
      if (req0_ready | req1_ready) begin
        rsp_r      <= r;
        rsp_ovf    <= ovf;
        last_grant <= req1_ready;
      end
      ovf_sticky <= (ovf_sticky & ~ovf_clr) | ({req1_ready, req0_ready} & {2{ovf}});
    end
  end
endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: self-checking scoreboard bench for calc_arbiter
module tb_calc_arbiter;
  logic       clk = 1'b0;
  logic       reset, en;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid, rsp_ovf;
  logic [3:0] rsp_r;
  logic [1:0] ovf_sticky, ovf_clr;
  int         checks = 0;
  int         errors = 0;
  logic [5:0] q[$];
  logic [5:0] mon_e;
  logic [1:0] mon_v;
  logic       ml = 1'b1;
  logic [1:0] ms = 2'b00;
  bit         mon_on = 1'b0;
  calc_arbiter #(.W(4)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_r(rsp_r), .rsp_ovf(rsp_ovf),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] calc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, x, y, res;
    sa = $signed(a);
    sb = $signed(b);
    x = op[2] ? sb : sa;
    y = op[2] ? sa : sb;
    if (op[1]) res = (y < 0) ? -y : y;
    else if (op[0]) res = x - y;
    else res = x + y;
    calc = {(res < -8) || (res > 7), res[3:0]};
  endfunction
  task automatic drive(input logic e, input logic rst,
                       input logic p0, input logic [2:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic p1, input logic [2:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                       input logic [1:0] clr);
    logic g0, g1;
    logic [4:0] res;
    en = e; reset = rst; ovf_clr = clr;
    req0_valid = p0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = p1; req1_op = o1; req1_a = a1; req1_b = b1;
    g0 = 1'b0; g1 = 1'b0;
    if (e && !rst) begin
      if (p0 && p1) begin
        if (ml) g0 = 1'b1;
        else g1 = 1'b1;
      end else begin
        g0 = p0;
        g1 = p1;
      end
    end
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== {g1, g0}) begin
      errors++;
      $display("FAIL ready: got %b expected %b at %0t", {req1_ready, req0_ready}, {g1, g0}, $time);
    end
    @(posedge clk);
    if (rst) begin
      ml = 1'b1;
      ms = 2'b00;
      q.delete();
    end else begin
      res = g1 ? calc(o1, a1, b1) : calc(o0, a0, b0);
      ms = (ms & ~clr) | ({g1, g0} & {2{res[4]}});
      if (g0 || g1) begin
        q.push_back({g1, res});
        ml = g1;
      end
    end
    @(negedge clk);
  endtask
  task automatic idle(input logic [1:0] clr);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 3'b000, 4'h0, 4'h0, clr);
  endtask
  task automatic r0(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [1:0] clr);
    drive(1'b1, 1'b0, 1'b1, op, a, b, 1'b0, 3'b000, 4'h0, 4'h0, clr);
  endtask
  task automatic r1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [1:0] clr);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 4'h0, 4'h0, 1'b1, op, a, b, clr);
  endtask
  always @(negedge clk) begin
    if (mon_on) begin
      mon_v = 2'b00;
      if (q.size() > 0) begin
        mon_e = q[0];
        mon_v = mon_e[5] ? 2'b10 : 2'b01;
      end
      checks++;
      if ({rsp1_valid, rsp0_valid} !== mon_v) begin
        errors++;
        $display("FAIL rsp_valid: got %b expected %b at %0t", {rsp1_valid, rsp0_valid}, mon_v, $time);
      end
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        checks++;
        if ({rsp_ovf, rsp_r} !== mon_e[4:0]) begin
          errors++;
          $display("FAIL rsp_data: got ovf=%b r=%h expected ovf=%b r=%h at %0t", rsp_ovf, rsp_r, mon_e[4], mon_e[3:0], $time);
        end
      end
      checks++;
      if (ovf_sticky !== ms) begin
        errors++;
        $display("FAIL ovf_sticky: got %b expected %b at %0t", ovf_sticky, ms, $time);
      end
    end
  end
  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 3'b000, 4'h0, 4'h0, 2'b00);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 3'b000, 4'h0, 4'h0, 2'b00);
  endtask
  task automatic test_reset();
    do_reset();
    mon_on = 1'b1;
    checks++;
    if ({rsp1_valid, rsp0_valid, rsp_ovf, rsp_r, ovf_sticky} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b ovf=%b r=%h sticky=%b expected all zero", {rsp1_valid, rsp0_valid}, rsp_ovf, rsp_r, ovf_sticky);
    end
  endtask
  task automatic test_single0();
    r0(3'b000, 4'h3, 4'h4, 2'b00);
    checks++;
    if (!(rsp0_valid === 1'b1 && rsp1_valid === 1'b0 && rsp_r === 4'h7 && rsp_ovf === 1'b0)) begin
      errors++;
      $display("FAIL single0: got v=%b r=%h ovf=%b expected v=01 r=7 ovf=0", {rsp1_valid, rsp0_valid}, rsp_r, rsp_ovf);
    end
    idle(2'b00);
    checks++;
    if (rsp_r !== 4'h7) begin
      errors++;
      $display("FAIL rsp_hold: got %h expected 7", rsp_r);
    end
  endtask
  task automatic test_sticky();
    r1(3'b000, 4'h7, 4'h1, 2'b00);
    checks++;
    if (!(rsp1_valid === 1'b1 && rsp_r === 4'h8 && rsp_ovf === 1'b1 && ovf_sticky === 2'b10)) begin
      errors++;
      $display("FAIL sticky_set: got v1=%b r=%h ovf=%b sticky=%b expected 1 8 1 10", rsp1_valid, rsp_r, rsp_ovf, ovf_sticky);
    end
    idle(2'b10);
    checks++;
    if (ovf_sticky !== 2'b00) begin
      errors++;
      $display("FAIL sticky_clr: got %b expected 00", ovf_sticky);
    end
    r1(3'b000, 4'h7, 4'h1, 2'b10);
    checks++;
    if (ovf_sticky !== 2'b10) begin
      errors++;
      $display("FAIL sticky_set_wins: got %b expected 10", ovf_sticky);
    end
    idle(2'b10);
  endtask
  task automatic test_opcodes();
    logic [2:0] ops[7] = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b100, 3'b111};
    logic [3:0] bs[7]  = '{4'hB, 4'hB, 4'hB, 4'hB, 4'h8, 4'hB, 4'h8};
    logic [3:0] rs[7]  = '{4'h7, 4'h9, 4'h5, 4'h2, 4'h8, 4'hD, 4'h2};
    logic       os[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      r0(ops[i], 4'h2, bs[i], 2'b00);
      checks++;
      if (rsp_r !== rs[i] || rsp_ovf !== os[i]) begin
        errors++;
        $display("FAIL opcode %b: got r=%h ovf=%b expected r=%h ovf=%b", ops[i], rsp_r, rsp_ovf, rs[i], os[i]);
      end
    end
    idle(2'b11);
  endtask
  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 3'b000, 4'h1, 4'h1, 1'b1, 3'b000, 4'h2, 4'h2, 2'b00);
      checks++;
      if ({rsp1_valid, rsp0_valid} !== ((i % 2) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL round_robin %0d: got %b expected %b", i, {rsp1_valid, rsp0_valid}, (i % 2) ? 2'b10 : 2'b01);
      end
    end
    idle(2'b00);
  endtask
  task automatic test_enable();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 3'b000, 4'h1, 4'h2, 1'b1, 3'b001, 4'h5, 4'h1, 2'b00);
      checks++;
      if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
        errors++;
        $display("FAIL en_off %0d: got %b expected 00", i, {rsp1_valid, rsp0_valid});
      end
    end
    drive(1'b1, 1'b0, 1'b1, 3'b000, 4'h1, 4'h2, 1'b1, 3'b001, 4'h5, 4'h1, 2'b00);
    checks++;
    if (!(rsp0_valid === 1'b1 && rsp_r === 4'h3)) begin
      errors++;
      $display("FAIL en_first: got v0=%b r=%h expected 1 3", rsp0_valid, rsp_r);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 3'b001, 4'h5, 4'h1, 2'b00);
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL en_drop: got %b expected 00", {rsp1_valid, rsp0_valid});
    end
    idle(2'b00);
  endtask
  task automatic test_reset_mid();
    r0(3'b000, 4'h7, 4'h1, 2'b00);
    drive(1'b1, 1'b1, 1'b1, 3'b000, 4'h3, 4'h4, 1'b0, 3'b000, 4'h0, 4'h0, 2'b00);
    checks++;
    if (!(rsp0_valid === 1'b0 && rsp_r === 4'h0 && ovf_sticky === 2'b00)) begin
      errors++;
      $display("FAIL reset_mid: got v0=%b r=%h sticky=%b expected 0 0 00", rsp0_valid, rsp_r, ovf_sticky);
    end
    idle(2'b00);
    idle(2'b00);
  endtask
  task automatic test_back_to_back();
    r0(3'b000, 4'h5, 4'h5, 2'b00);
    r1(3'b101, 4'h1, 4'h6, 2'b00);
    r0(3'b110, 4'h9, 4'h0, 2'b00);
    r1(3'b010, 4'h0, 4'h8, 2'b00);
    checks++;
    if (!(rsp1_valid === 1'b1 && rsp_r === 4'h8 && rsp_ovf === 1'b1)) begin
      errors++;
      $display("FAIL back_to_back: got v1=%b r=%h ovf=%b expected 1 8 1", rsp1_valid, rsp_r, rsp_ovf);
    end
    idle(2'b11);
  endtask
  initial begin
    test_reset();
    test_single0();
    test_sticky();
    test_opcodes();
    test_round_robin();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
